// File: rtl/mux_arb_2to1.sv
// ============================================================================
// Module      : mux_arb_2to1
// Description : Two-source valid/ready stream arbiter feeding a one-entry
//               output register. The grant is exported on 'sel' (0 = A,
//               1 = B) so a downstream mux_2to1 can share it.
//               Build option: define MUX_ARB_RR_EN for round-robin
//               arbitration on contention; otherwise A has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_arb_2to1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  // source A stream
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  // source B stream
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  // merged output stream
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  input  logic             y_ready,
  // current grant: 0 selects A, 1 selects B
  output logic             sel
);

  // Output register and its next state.
  logic [WIDTH-1:0] y_data_q;
  logic [WIDTH-1:0] y_data_d;
  logic             y_valid_q;
  logic             y_valid_d;

  // Last driven grant; reused whenever nobody is requesting or we are stalled.
  logic             sel_q;
  logic             sel_d;

  // Combinational handshake terms.
  logic             w_load_en;
  logic             w_grant;
  logic             w_xfer_a;
  logic             w_xfer_b;
  logic             w_xfer_in;

`ifdef MUX_ARB_RR_EN
  // Last-grant state: which source completed the most recent input transfer.
  localparam logic [0:0] LAST_A = 1'b0;
  localparam logic [0:0] LAST_B = 1'b1;

  logic [0:0] last_q;
  logic [0:0] last_d;
`endif

  // The output slot can accept a new word when empty or draining this cycle.
  assign w_load_en = !y_valid_q || y_ready;

  // Input handshakes; readys are held low during reset.
  assign w_xfer_a  = a_ready && a_valid;
  assign w_xfer_b  = b_ready && b_valid;
  assign w_xfer_in = w_xfer_a || w_xfer_b;

`ifdef MUX_ARB_RR_EN
  // Last-grant state register: reset to LAST_B so A wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= LAST_B;
    end else begin
      last_q <= last_d;
    end
  end

  // Last-grant next state: moves only on a completed input transfer.
  always_comb begin
    last_d = last_q;
    if (w_xfer_a) begin
      last_d = LAST_A;
    end else if (w_xfer_b) begin
      last_d = LAST_B;
    end
  end
`endif

  // Grant selection: hold while stalled or idle, otherwise arbitrate.
  always_comb begin
    w_grant = sel_q;
    if (w_load_en) begin
      case ({a_valid, b_valid})
        2'b10:   w_grant = 1'b0;
        2'b01:   w_grant = 1'b1;
`ifdef MUX_ARB_RR_EN
        2'b11:   w_grant = (last_q == LAST_A);
`else
        2'b11:   w_grant = 1'b0;
`endif
        default: w_grant = sel_q;
      endcase
    end
  end

  // Handshake outputs; data inputs never reach these, only valids and state.
  always_comb begin
    sel     = w_grant;
    a_ready = !rst && w_load_en && !w_grant && a_valid;
    b_ready = !rst && w_load_en &&  w_grant && b_valid;
  end

  // Remember the grant so it can be held when no source is requesting.
  assign sel_d = w_grant;

  // Grant register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
    end
  end

  // Output slot next state: load on input transfer, empty on a bare drain.
  always_comb begin
    y_data_d  = y_data_q;
    y_valid_d = y_valid_q;
    if (w_xfer_in) begin
      y_valid_d = 1'b1;
      y_data_d  = w_grant ? b_data : a_data;
    end else if (w_load_en) begin
      y_valid_d = 1'b0;
    end
  end

  // Output register: reset discards any word still held.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
    end else begin
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
    end
  end

  assign y_data  = y_data_q;
  assign y_valid = y_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_arb_2to1.sv
// ============================================================================
// Module      : tb_mux_arb_2to1
// Description : Scoreboard bench for mux_arb_2to1. The driver predicts each
//               input transfer from the arbitration rules and queues the
//               expected word; a separate monitor pops on every output
//               transfer. Honours MUX_ARB_RR_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_arb_2to1;

  localparam int WIDTH = 8;

`ifdef MUX_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] y_data;
  logic             y_valid;
  logic             y_ready;
  logic             sel;

  always #5 clk = ~clk;

  mux_arb_2to1 #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_data  (a_data),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b_data  (b_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .y_data  (y_data),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .sel     (sel)
  );

  // Scoreboard: words expected to appear on the output, in order.
  logic [WIDTH-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Reference model state.
  bit               m_last_b    = 1'b1;  // last input transfer came from B
  bit               m_sel       = 1'b0;
  bit               m_sel_known = 1'b0;
  bit               pend_rst    = 1'b0;
  bit               pend_push   = 1'b0;
  logic [WIDTH-1:0] pend_word   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Arbitration rule: single requester wins; contention goes to A under fixed
  // priority, or to whoever did not win last time under round-robin.
  function automatic bit model_grant(input bit av, input bit bv, input bit last_b,
                                     input bit prev, input bit rr);
    if (av && !bv) return 1'b0;
    if (bv && !av) return 1'b1;
    if (av && bv)  return rr ? !last_b : 1'b0;
    return prev;
  endfunction

  // One clock of stimulus plus the model's prediction for that cycle.
  task automatic cyc(input bit r, input bit av, input logic [WIDTH-1:0] ad,
                     input bit bv, input logic [WIDTH-1:0] bd, input bit yr);
    bit occ, stall, g, g_known, ea, eb;
    @(posedge clk);
    if (pend_rst) exp_q.delete();
    else if (pend_push) exp_q.push_back(pend_word);
    #2;
    rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
    #1;
    occ   = (exp_q.size() != 0);
    stall = occ && !yr;
    if (stall || (!av && !bv)) begin
      g = m_sel; g_known = m_sel_known;
    end else begin
      g = model_grant(av, bv, m_last_b, m_sel, RR); g_known = 1'b1;
    end
    ea = !r && !stall && av && !g;
    eb = !r && !stall && bv &&  g;
    chk("a_ready", a_ready, ea);
    chk("b_ready", b_ready, eb);
    chk("ready_excl", a_ready && b_ready, 0);
    if (!r && g_known) chk("sel", sel, g);
    pend_rst  = r;
    pend_push = ea || eb;
    pend_word = ea ? ad : bd;
    if (r) begin
      m_last_b = 1'b1; m_sel_known = 1'b0;
    end else begin
      if (g_known) begin m_sel = g; m_sel_known = 1'b1; end
      if (ea) m_last_b = 1'b0;
      if (eb) m_last_b = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  // Monitor: output occupancy must match the scoreboard, and every output
  // transfer must carry the oldest expected word.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("y_valid", y_valid, exp_q.size() != 0);
      if (y_valid === 1'b1 && y_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL y_spurious: got word %0h expected none at %0t", y_data, $time);
        end else begin
          chk("y_data", y_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; a_valid = 1'b0; a_data = '0; b_valid = 1'b0; b_data = '0; y_ready = 1'b0;

    // Reset held two cycles with both sources requesting.
    cyc(1'b1, 1'b1, 8'h01, 1'b1, 8'h02, 1'b1);
    cyc(1'b1, 1'b1, 8'h01, 1'b1, 8'h02, 1'b1);
    mon_en = 1'b1;
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_data", y_data, 0);

    // Single source, accepted from the first cycle after reset.
    cyc(1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h22, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b1);
    idle(2);

    // Continuous contention.
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
    idle(2);

    // Backpressure holding 0x5C.
    cyc(1'b0, 1'b1, 8'h5C, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 8'hA1, 1'b1, 8'hB2, 1'b0);
      chk("bp_y_data", y_data, 8'h5C);
    end
    cyc(1'b0, 1'b1, 8'hA1, 1'b1, 8'hB2, 1'b1);
    cyc(1'b0, 1'b1, 8'hA3, 1'b1, 8'hB4, 1'b1);
    idle(2);

    // Mid-stream reset while a word is held.
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h77, 1'b0);
    cyc(1'b0, 1'b1, 8'h66, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 8'h99, 1'b1, 8'h98, 1'b0);
    cyc(1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
    chk("mid_rst_y_valid", y_valid, 0);
    chk("mid_rst_grant_a", sel, 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
    idle(2);

    // Random traffic with occasional reset.
    for (int i = 0; i < 1000; i++) begin
      cyc(($urandom_range(0, 149) == 0),
          1'($urandom_range(0, 1)), 8'($urandom),
          1'($urandom_range(0, 1)), 8'($urandom),
          ($urandom_range(0, 3) != 0));
    end
    idle(3);
    chk("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
